// File: rtl/calc_core_bcd_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_core_bcd_if
// Desc     : Keypad command channel into calc_core_bcd (valid/ready).
//            The keypad decoder drives the master side, the core the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_core_bcd_if;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       cmd_ready;

   modport master (output cmd, output cmd_valid, input  cmd_ready);
   modport slave  (input  cmd, input  cmd_valid, output cmd_ready);
endinterface : calc_core_bcd_if
`default_nettype wire

// File: rtl/calc_core_bcd.sv
`default_nettype none
// ============================================================================
// Module   : calc_core_bcd
// Desc     : Decimal entry calculator core. Accumulates an NDIGITS decimal
//            operand from keypad commands, performs add / subtract / serial
//            shift-add multiply, converts the displayed value to BCD with a
//            serial double-dabble and scans the digits onto a shared bus.
// Revision : 1.0 - initial release
// ============================================================================
module calc_core_bcd #(
   parameter int NDIGITS  = 8,
   parameter int VALW     = 27,
   parameter int SCAN_DIV = 1000
) (
   input  logic                clock,
   input  logic                reset,
   calc_core_bcd_if.slave      cmd_if,
   output logic [1:0]          o_status,
   output logic [VALW-1:0]     o_value,
   output logic [3:0]          o_data,
   output logic [NDIGITS-1:0]  o_pos
);

   function automatic logic [63:0] f_pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [VALW-1:0] c_MAXV = VALW'(f_pow10(NDIGITS) - 64'd1);
   localparam int c_BW = 4 * NDIGITS;
   localparam int c_CW = $clog2(VALW + 1);
   localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [3:0] c_CMD_ADD  = 4'd10;
   localparam logic [3:0] c_CMD_SUB  = 4'd11;
   localparam logic [3:0] c_CMD_MUL  = 4'd12;
   localparam logic [3:0] c_CMD_CLR  = 4'd13;
   localparam logic [3:0] c_CMD_EQ   = 4'd14;
   localparam logic [3:0] c_CMD_BKSP = 4'd15;

   typedef enum logic [2:0] {
      S_ENTRY     = 3'd0,
      S_BUSY_MUL  = 3'd1,
      S_BUSY_CONV = 3'd2,
      S_RESULT    = 3'd3,
      S_ERROR     = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2,
      OP_MUL  = 2'd3
   } op_t;

   // architectural state
   state_t              r_state;
   logic [VALW-1:0]     r_entry;
   logic [VALW-1:0]     r_acc;
   logic [VALW-1:0]     r_value;
   op_t                 r_pend;
   logic                r_fresh;     // a digit was entered since the last op key
   logic                r_ret_res;   // conversion ends in RESULT rather than ENTRY

   // serial engines (multiply and double-dabble share the step counter)
   logic [c_CW-1:0]     r_cnt;
   logic [2*VALW-1:0]   r_mcand;
   logic [VALW-1:0]     r_mplier;
   logic [2*VALW-1:0]   r_prod;
   logic [VALW-1:0]     r_dd_bin;
   logic [c_BW-1:0]     r_dd_bcd;
   logic [c_BW-1:0]     r_bcd_img;

   // display scan
   logic [c_SW-1:0]     r_scan;
   logic [NDIGITS-1:0]  r_pos;
   logic [3:0]          r_data;

   // next-state / control
   state_t              w_state_nxt;
   logic [VALW-1:0]     w_entry_nxt;
   logic [VALW-1:0]     w_acc_nxt;
   logic [VALW-1:0]     w_value_nxt;
   op_t                 w_pend_nxt;
   logic                w_fresh_nxt;
   logic                w_ret_res_nxt;
   logic                w_start_conv;
   logic                w_start_mul;
   logic                w_is_eq;
   logic                w_commit;
   logic [VALW-1:0]     w_result;
   op_t                 w_new_op;

   logic                w_accept;
   logic                w_is_clr;
   logic [VALW-1:0]     w_dig_base;
   logic [VALW+3:0]     w_dig_cand;
   logic                w_dig_ok;
   logic [VALW-1:0]     w_bksp;
   logic [VALW:0]       w_sum;
   logic                w_add_ovf;
   logic                w_sub_neg;
   logic [VALW-1:0]     w_diff;
   logic [2*VALW-1:0]   w_prod_step;
   logic                w_mul_last;
   logic                w_mul_ovf;
   logic                w_conv_done;
   logic [c_BW-1:0]     w_dd_adj;
   logic [NDIGITS-1:0]  w_nz;
   logic                w_run;
   logic [3:0]          w_digit;
   logic                w_show;

   // Clear-all must get through even while a serial engine is running.
   assign cmd_if.cmd_ready = (r_state == S_ENTRY) || (r_state == S_RESULT) ||
                             (r_state == S_ERROR) ||
                             (cmd_if.cmd_valid && (cmd_if.cmd == c_CMD_CLR));
   assign w_accept = cmd_if.cmd_valid && cmd_if.cmd_ready;
   assign w_is_clr = w_accept && (cmd_if.cmd == c_CMD_CLR);

   // A digit in RESULT starts a fresh number instead of extending the result.
   assign w_dig_base = (r_state == S_RESULT) ? '0 : r_entry;
   assign w_dig_cand = ({4'd0, w_dig_base} << 3) + ({4'd0, w_dig_base} << 1) +
                       {{VALW{1'b0}}, cmd_if.cmd};
   assign w_dig_ok   = (w_dig_cand <= {4'd0, c_MAXV});

   // In RESULT the entry register holds the result, so this trims the display.
   assign w_bksp    = r_entry / VALW'(10);
   assign w_sum     = {1'b0, r_acc} + {1'b0, r_entry};
   assign w_add_ovf = (w_sum > {1'b0, c_MAXV});
   assign w_sub_neg = (r_acc < r_entry);
   assign w_diff    = r_acc - r_entry;

   assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_last  = (r_cnt == c_CW'(VALW - 1));
   assign w_mul_ovf   = (w_prod_step > {{VALW{1'b0}}, c_MAXV});
   assign w_conv_done = (r_cnt == c_CW'(VALW));

   // Command decode and next-state computation for the control FSM.
   always_comb begin
      w_state_nxt   = r_state;
      w_entry_nxt   = r_entry;
      w_acc_nxt     = r_acc;
      w_value_nxt   = r_value;
      w_pend_nxt    = r_pend;
      w_fresh_nxt   = r_fresh;
      w_ret_res_nxt = r_ret_res;
      w_start_conv  = 1'b0;
      w_start_mul   = 1'b0;
      w_commit      = 1'b0;
      w_result      = r_entry;
      w_is_eq       = (cmd_if.cmd == c_CMD_EQ);
      case (cmd_if.cmd)
         c_CMD_ADD: w_new_op = OP_ADD;
         c_CMD_SUB: w_new_op = OP_SUB;
         c_CMD_MUL: w_new_op = OP_MUL;
         default:   w_new_op = OP_NONE;
      endcase

      if (w_is_clr) begin
         w_state_nxt   = S_ENTRY;
         w_entry_nxt   = '0;
         w_acc_nxt     = '0;
         w_value_nxt   = '0;
         w_pend_nxt    = OP_NONE;
         w_fresh_nxt   = 1'b0;
         w_ret_res_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ENTRY, S_RESULT: begin
               if (w_accept) begin
                  if (cmd_if.cmd <= 4'd9) begin
                     if (w_dig_ok) begin
                        w_entry_nxt   = w_dig_cand[VALW-1:0];
                        w_value_nxt   = w_dig_cand[VALW-1:0];
                        w_fresh_nxt   = 1'b1;
                        w_ret_res_nxt = 1'b0;
                        w_start_conv  = 1'b1;
                        w_state_nxt   = S_BUSY_CONV;
                     end
                  end else if (cmd_if.cmd == c_CMD_BKSP) begin
                     w_entry_nxt   = w_bksp;
                     w_value_nxt   = w_bksp;
                     w_ret_res_nxt = 1'b0;
                     w_start_conv  = 1'b1;
                     w_state_nxt   = S_BUSY_CONV;
                  end else if (w_is_eq || (w_new_op != OP_NONE)) begin
                     if (!w_is_eq && (r_pend != OP_NONE) && !r_fresh) begin
                        // back-to-back op keys only change the pending operator
                        w_pend_nxt = w_new_op;
                     end else begin
                        w_fresh_nxt   = 1'b0;
                        w_ret_res_nxt = w_is_eq;
                        w_pend_nxt    = w_new_op;
                        case (r_pend)
                           OP_MUL: begin
                              w_start_mul = 1'b1;
                              w_state_nxt = S_BUSY_MUL;
                              if (!w_is_eq) w_entry_nxt = '0;
                           end
                           OP_ADD: begin
                              if (w_add_ovf) w_state_nxt = S_ERROR;
                              else begin
                                 w_result = w_sum[VALW-1:0];
                                 w_commit = 1'b1;
                              end
                           end
                           OP_SUB: begin
                              if (w_sub_neg) w_state_nxt = S_ERROR;
                              else begin
                                 w_result = w_diff;
                                 w_commit = 1'b1;
                              end
                           end
                           default: begin
                              w_result = r_entry;
                              w_commit = 1'b1;
                           end
                        endcase
                        if (w_commit) begin
                           // equals keeps the result in entry so it can be chained
                           w_acc_nxt    = w_result;
                           w_value_nxt  = w_result;
                           w_entry_nxt  = w_is_eq ? w_result : '0;
                           w_start_conv = 1'b1;
                           w_state_nxt  = S_BUSY_CONV;
                        end
                     end
                  end
               end
            end
            S_BUSY_MUL: begin
               if (w_mul_last) begin
                  if (w_mul_ovf) w_state_nxt = S_ERROR;
                  else begin
                     w_acc_nxt    = w_prod_step[VALW-1:0];
                     w_value_nxt  = w_prod_step[VALW-1:0];
                     if (r_ret_res) w_entry_nxt = w_prod_step[VALW-1:0];
                     w_start_conv = 1'b1;
                     w_state_nxt  = S_BUSY_CONV;
                  end
               end
            end
            S_BUSY_CONV: begin
               if (w_conv_done) w_state_nxt = r_ret_res ? S_RESULT : S_ENTRY;
            end
            S_ERROR: begin
               w_state_nxt = S_ERROR;
            end
            default: begin
               w_state_nxt = S_ENTRY;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_ENTRY;
      else       r_state <= w_state_nxt;
   end

   // Operand, accumulator and displayed-value registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_entry   <= '0;
         r_acc     <= '0;
         r_value   <= '0;
         r_pend    <= OP_NONE;
         r_fresh   <= 1'b0;
         r_ret_res <= 1'b0;
      end else begin
         r_entry   <= w_entry_nxt;
         r_acc     <= w_acc_nxt;
         r_value   <= w_value_nxt;
         r_pend    <= w_pend_nxt;
         r_fresh   <= w_fresh_nxt;
         r_ret_res <= w_ret_res_nxt;
      end
   end

   // Double-dabble adjust: every BCD digit of 5 or more gets +3 before the shift.
   always_comb begin
      w_dd_adj = r_dd_bcd;
      for (int i = 0; i < NDIGITS; i++) begin
         if (r_dd_bcd[4*i +: 4] >= 4'd5) w_dd_adj[4*i +: 4] = r_dd_bcd[4*i +: 4] + 4'd3;
      end
   end

   // Serial multiplier and binary-to-BCD converter, plus the latched BCD image.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_prod    <= '0;
         r_dd_bin  <= '0;
         r_dd_bcd  <= '0;
         r_bcd_img <= '0;
      end else if (w_is_clr) begin
         r_cnt     <= '0;
         r_bcd_img <= '0;
      end else if (w_start_mul) begin
         r_mcand  <= {{VALW{1'b0}}, r_acc};
         r_mplier <= r_entry;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (w_start_conv) begin
         r_dd_bin <= w_value_nxt;
         r_dd_bcd <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_BUSY_MUL) begin
         r_prod   <= w_prod_step;
         r_mcand  <= {r_mcand[2*VALW-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[VALW-1:1]};
         r_cnt    <= r_cnt + c_CW'(1);
      end else if (r_state == S_BUSY_CONV) begin
         if (w_conv_done) begin
            r_bcd_img <= r_dd_bcd;
         end else begin
            r_dd_bcd <= {w_dd_adj[c_BW-2:0], r_dd_bin[VALW-1]};
            r_dd_bin <= {r_dd_bin[VALW-2:0], 1'b0};
            r_cnt    <= r_cnt + c_CW'(1);
         end
      end
   end

   // Select the digit at the active position and decide leading-zero blanking.
   always_comb begin
      w_run   = 1'b0;
      w_nz    = '0;
      w_digit = 4'd0;
      w_show  = 1'b1;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         w_run = w_run | (|r_bcd_img[4*i +: 4]);
         w_nz[i] = w_run;
      end
      for (int i = 0; i < NDIGITS; i++) begin
         if (r_pos[i]) begin
            w_digit = r_bcd_img[4*i +: 4];
            w_show  = (i == 0) || w_nz[i];
         end
      end
   end

   // Display scan: free-running position rotation and registered digit output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_scan <= '0;
         r_pos  <= NDIGITS'(1);
         r_data <= 4'd0;
      end else begin
         if (r_scan == c_SW'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            r_pos  <= (r_pos << 1) | NDIGITS'(r_pos[NDIGITS-1]);
         end else begin
            r_scan <= r_scan + c_SW'(1);
         end
         if (w_is_clr)                r_data <= 4'd0;
         else if (r_state == S_ERROR) r_data <= 4'hE;
         else if (w_show)             r_data <= w_digit;
         else                         r_data <= 4'hF;
      end
   end

   // Status encoding follows the FSM state.
   always_comb begin
      case (r_state)
         S_BUSY_MUL, S_BUSY_CONV: o_status = 2'b01;
         S_ERROR:                 o_status = 2'b10;
         S_RESULT:                o_status = 2'b11;
         default:                 o_status = 2'b00;
      endcase
   end

   assign o_value = r_value;
   assign o_data  = r_data;
   assign o_pos   = r_pos;

endmodule : calc_core_bcd
`default_nettype wire

// File: tb/tb_calc_core_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_core_bcd
// Desc     : Directed bench for calc_core_bcd. Settled {status,value} pairs
//            are predicted into a queue and compared by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_core_bcd;

   localparam int NDIGITS  = 8;
   localparam int VALW     = 27;
   localparam int SCAN_DIV = 4;

   typedef struct packed {
      logic [1:0]      st;
      logic [VALW-1:0] val;
   } settle_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [1:0]         status;
   logic [VALW-1:0]    value;
   logic [3:0]         data;
   logic [NDIGITS-1:0] pos;

   int      n_checks = 0;
   int      n_pass   = 0;
   int      n_edges  = 0;
   settle_t exp_q[$];
   settle_t last_settled = '0;

   calc_core_bcd_if u_if ();

   calc_core_bcd #(
      .NDIGITS (NDIGITS),
      .VALW    (VALW),
      .SCAN_DIV(SCAN_DIV)
   ) u_dut (
      .clock   (clk),
      .reset   (reset),
      .cmd_if  (u_if),
      .o_status(status),
      .o_value (value),
      .o_data  (data),
      .o_pos   (pos)
   );

   always #5 clk = ~clk;

   // free-running edge count, used to predict the scan position
   always @(posedge clk) if (!reset) n_edges <= n_edges + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
   endtask

   task automatic fail_bound(input string nm);
      n_checks++;
      $display("FAIL %s: timeout waiting on DUT", nm);
   endtask

   // monitor: each new non-busy {status,value} pair is one DUT response
   always @(negedge clk) begin
      settle_t cur, e;
      cur = {status, value};
      if (!reset && status != 2'b01 && cur != last_settled) begin
         last_settled = cur;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_settle: got status %0d value %0d, none expected", status, value);
         end else begin
            e = exp_q.pop_front();
            chk("settle_status", 64'(status), 64'(e.st));
            chk("settle_value",  64'(value),  64'(e.val));
         end
      end
   end

   task automatic expect_settle(input logic [1:0] st, input int unsigned v);
      settle_t e;
      e.st  = st;
      e.val = VALW'(v);
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [3:0] c);
      int g = 0;
      @(negedge clk);
      u_if.cmd = c;
      u_if.cmd_valid = 1'b1;
      while (!u_if.cmd_ready && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (!u_if.cmd_ready) fail_bound("cmd_ready");
      @(posedge clk);
      #1 u_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int g = 0;
      @(negedge clk);
      while (status == 2'b01 && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (status == 2'b01) fail_bound(nm);
   endtask

   task automatic key(input logic [3:0] c);
      send(c);
      wait_idle("idle");
   endtask

   // enter a number digit by digit; every digit yields a new entry value
   task automatic enter_num(input int unsigned n);
      int unsigned dq[$];
      int unsigned t;
      int unsigned acc;
      t = n;
      do begin
         dq.push_front(t % 10);
         t = t / 10;
      end while (t != 0);
      acc = 0;
      foreach (dq[i]) begin
         acc = acc * 10 + dq[i];
         expect_settle(2'b00, acc);
         key(4'(dq[i]));
      end
   endtask

   // data lags pos by one cycle: pos seen at one negedge owns data at the next
   task automatic check_display(input string nm, input logic [31:0] expd);
      logic [7:0] seen = '0;
      logic [7:0] prev;
      int g = 0;
      @(negedge clk);
      prev = pos;
      while (seen != 8'hFF && g < 200) begin
         @(negedge clk);
         g++;
         for (int k = 0; k < 8; k++) begin
            if (prev == (8'd1 << k) && !seen[k]) begin
               seen[k] = 1'b1;
               chk($sformatf("%s_pos%0d", nm, k), 64'(data), 64'(expd[4*k +: 4]));
            end
         end
         prev = pos;
      end
      if (seen != 8'hFF) fail_bound(nm);
   endtask

   initial begin
      int busy;
      logic ready_seen;
      int g;
      u_if.cmd = 4'd0;
      u_if.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_status", 64'(status), 64'd0);
      chk("reset_value",  64'(value),  64'd0);
      chk("reset_ready",  64'(u_if.cmd_ready), 64'd1);
      chk("reset_pos",    64'(pos),    64'd1);
      chk("reset_data",   64'(data),   64'd0);

      // 1,2,3 -> 123 shown as 3,2,1 with blanked leading zeros
      enter_num(123);
      chk("entry_status", 64'(status), 64'd0);
      check_display("disp123", 32'hFFFF_F123);

      // 45 + 55 = 100, then a digit starts a new entry
      expect_settle(2'b00, 0);
      key(4'd13);
      enter_num(45);
      key(4'd10);
      enter_num(55);
      expect_settle(2'b11, 100);
      key(4'd14);
      expect_settle(2'b00, 7);
      key(4'd7);

      // 12345 * 678 = 8369910 through the serial multiplier
      expect_settle(2'b00, 0);
      key(4'd13);
      enter_num(12345);
      key(4'd12);
      enter_num(678);
      expect_settle(2'b11, 8369910);
      send(4'd14);
      busy = 0;
      ready_seen = 1'b0;
      g = 0;
      @(negedge clk);
      while (status == 2'b01 && g < 300) begin
         busy++;
         if (u_if.cmd_ready) ready_seen = 1'b1;
         @(negedge clk);
         g++;
      end
      if (status == 2'b01) fail_bound("mul_busy");
      chk("mul_busy_ge_valw", 64'(busy >= VALW), 64'd1);
      chk("mul_ready_low",    64'(ready_seen),   64'd0);

      // add overflow -> error glyph everywhere, digits dropped, clear recovers
      expect_settle(2'b00, 0);
      key(4'd13);
      enter_num(99999999);
      key(4'd10);
      enter_num(1);
      expect_settle(2'b10, 1);
      key(4'd14);
      check_display("disp_err", 32'hEEEE_EEEE);
      send(4'd5);
      repeat (3) @(negedge clk);
      chk("err_digit_status", 64'(status), 64'd2);
      chk("err_digit_value",  64'(value),  64'd1);
      expect_settle(2'b00, 0);
      key(4'd13);

      // ninth digit is ignored; 5 - 7 is an error
      enter_num(99999999);
      send(4'd9);
      repeat (3) @(negedge clk);
      chk("ovf_digit_status", 64'(status), 64'd0);
      chk("ovf_digit_value",  64'(value),  64'd99999999);
      expect_settle(2'b00, 0);
      key(4'd13);
      enter_num(5);
      key(4'd11);
      enter_num(7);
      expect_settle(2'b10, 7);
      key(4'd14);
      expect_settle(2'b00, 0);
      key(4'd13);

      // abort 9999 * 9999 mid-multiply; scan keeps running
      enter_num(9999);
      key(4'd12);
      enter_num(9999);
      send(4'd14);
      repeat (4) @(negedge clk);
      chk("abort_busy", 64'(status), 64'd1);
      chk("abort_pos_before", 64'(pos), 64'(8'd1 << ((n_edges / SCAN_DIV) % 8)));
      expect_settle(2'b00, 0);
      u_if.cmd = 4'd13;
      u_if.cmd_valid = 1'b1;
      #1 chk("abort_ready", 64'(u_if.cmd_ready), 64'd1);
      @(posedge clk);
      #1 u_if.cmd_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk($sformatf("scan_pos_%0d", k), 64'(pos), 64'(8'd1 << ((n_edges / SCAN_DIV) % 8)));
      end
      chk("abort_status", 64'(status), 64'd0);
      chk("abort_value",  64'(value),  64'd0);

      // backspace on 456 -> 45
      enter_num(456);
      expect_settle(2'b00, 45);
      key(4'd15);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_calc_core_bcd
`default_nettype wire

// File: doc/calc_core_bcd.md
Name: calc_core_bcd

Overview:
- Parametrised successor of the single-register decimal entry calculator.
- Accepts keypad commands through a valid/ready handshake and accumulates a decimal operand of NDIGITS digits.
- Performs add, subtract and sequential shift-add multiply, converts the displayed value to BCD with a sequential double-dabble, and time-multiplexes digits onto a shared display bus.
- Sits between the keypad decoder and the 7-segment driver.

Parameters:
- NDIGITS, 8, number of decimal display digits; max value MAXV = 10^NDIGITS-1.
- VALW, 27, binary value width; must satisfy 2^VALW > MAXV.
- SCAN_DIV, 1000, clock cycles each display position is held.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- cmd  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 clear-all, 14 equals, 15 backspace
- cmd_valid  in  1  cmd present this cycle
- cmd_ready  out  1  core accepts cmd this cycle
- status  out  2  00 entry, 01 busy, 10 error, 11 result shown
- value  out  VALW  currently displayed binary value
- data  out  4  BCD digit for active position; 4'hF = blank, 4'hE = error glyph
- pos  out  NDIGITS  one-hot active display position, bit0 = least significant digit

Behaviour:
- Reset is asynchronous and active-high, on reset; clock is clock.
- Reset values: entry=0, acc=0, pending_op=none, state=ENTRY, status=00, value=0, BCD image=0, cmd_ready=1, pos=1, data=0, scan counter=0.
- Handshake: cmd is accepted when cmd_valid && cmd_ready are high on a clock edge. cmd_ready=1 only in ENTRY, RESULT and ERROR. cmd 13 is always accepted, including while BUSY.
- States:
  - ENTRY: accepts all commands.
  - BUSY_MUL: VALW cycles.
  - BUSY_CONV: VALW+1 cycles.
  - RESULT: accepts all commands.
  - ERROR: only cmd 13 has effect; all other accepted cmds are dropped.
- Digit d:
  - entry <= entry*10+d.
  - If entry*10+d > MAXV, the digit is ignored (no state change, no conversion).
  - In RESULT, a digit first clears entry, then appends, and the state moves to ENTRY.
- Backspace: entry <= entry/10; in RESULT it acts on the displayed result.
- Op key (10/11/12):
  - If pending_op is none: acc <= entry.
  - Otherwise: acc <= acc (pending_op) entry.
  - Then pending_op <= new op, entry <= 0, displayed value = acc.
  - Consecutive op keys with no digit between them replace pending_op only.
- Equals (14): applies pending_op as above, sets pending_op=none and goes to RESULT. With no pending op, acc <= entry.
- Add: result > MAXV -> ERROR.
- Sub: acc < entry -> ERROR (no negatives).
- Mul:
  - Enters BUSY_MUL, one shift-add step per cycle, LSB-first over entry, with a 2*VALW-bit product.
  - After VALW cycles, product > MAXV -> ERROR; otherwise commit.
- Every change of the displayed value starts BUSY_CONV: double-dabble, one shift per cycle, then one cycle to latch the BCD image. Status is 01 during BUSY_MUL/BUSY_CONV.
- ERROR is entered directly from the arithmetic check, with no conversion.
- Clear-all (13), from any state including mid-multiply or mid-conversion: aborts the operation, loads reset values except the scan counter and pos, and goes to ENTRY on the next cycle.
- Display scan:
  - pos rotates left, bit NDIGITS-1 wraps to bit0, every SCAN_DIV cycles.
  - data is registered from the latched BCD image (1 cycle after the pos change), so the display holds the old image during BUSY.
  - Leading zeros are shown as 4'hF except position 0, which always shows its digit.
  - In ERROR, data=4'hE at every position.
- Latency: accepted digit -> value update next edge -> new BCD on data after VALW+2 cycles max. Multiply -> result after VALW + VALW+2 cycles.

Test Plan:
- Reset, then enter 1,2,3 -> value=123; after conversion the displayed digits are 3,2,1 at pos0..2 and F at pos3..7; status=00.
- Enter 45, add, 55, equals -> value=100, status=11; next digit 7 -> value=7, status=00.
- Enter 12345, mul, 678, equals -> status=01 for ≥VALW cycles, cmd_ready=0; then value=8369910, status=11.
- Enter 99999999, add, 1, equals -> status=10, data=E at all positions; then digit 5 -> ignored; clear-all -> status=00, value=0.
- Enter 99999999 then digit 9 -> ignored, value unchanged. Enter 5, sub, 7, equals -> status=10.
- During BUSY_MUL of 9999*9999, assert clear-all at cycle 5 -> status=00, value=0, pos scan continues uninterrupted; backspace on 456 -> value=45.
